// File: rtl/wb_regfile_stage.sv
// Writeback stage with GPR file, HI/LO, SYSCALL print/halt FSM and retired counter.
// Optional same-cycle write-to-read forwarding is enabled by defining WB_BYPASS_EN.
module wb_regfile_stage #(
    parameter logic [31:0] HALT_CODE = 32'd10,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic             wb_valid,
    input  logic             RegWrite,
    input  logic             LOWrite,
    input  logic             HIWrite,
    input  logic             JAL,
    input  logic             SYSCALL,
    input  logic             MemToReg,
    input  logic [4:0]       WbRegNum,
    input  logic [31:0]      PC,
    input  logic [31:0]      R1,
    input  logic [31:0]      R2,
    input  logic [31:0]      MemData,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    output logic [31:0]      rs_data,
    output logic [31:0]      rt_data,
    output logic [31:0]      hi,
    output logic [31:0]      lo,
    output logic             halted,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic {RUN, HALT} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_gpr [32];
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;
    logic              r_out_valid;
    logic [31:0]       r_out_data;
    logic [CNT_W-1:0]  r_retired;

    logic              w_commit;
    logic              w_we;
    logic [4:0]        w_waddr;
    logic [31:0]       w_wdata;
    logic              w_halt_req;
    logic              w_print;

    assign w_commit   = EN & wb_valid & (r_state == RUN);
    assign w_we       = w_commit & (JAL | (RegWrite & (WbRegNum != 5'd0)));
    assign w_waddr    = JAL ? 5'd31 : WbRegNum;
    assign w_wdata    = JAL ? (PC + 32'd4) : (MemToReg ? MemData : R1);
    // SYSCALL decisions use the pre-commit register contents
    assign w_halt_req = w_commit & SYSCALL & (r_gpr[2] == HALT_CODE);
    assign w_print    = w_commit & SYSCALL & (r_gpr[2] != HALT_CODE);

    always_comb begin
        w_state_next = r_state;
        if (r_state == RUN && w_halt_req)
            w_state_next = HALT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_retired   <= '0;
            for (int i = 0; i < 32; i++)
                r_gpr[i] <= 32'd0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= w_print;
            if (w_print)
                r_out_data <= r_gpr[4];
            if (w_we)
                r_gpr[w_waddr] <= w_wdata;
            if (w_commit && LOWrite)
                r_lo <= R1;
            if (w_commit && HIWrite)
                r_hi <= R2;
            if (w_commit)
                r_retired <= r_retired + 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        rs_data = (rs_addr == 5'd0) ? 32'd0 : r_gpr[rs_addr];
        rt_data = (rt_addr == 5'd0) ? 32'd0 : r_gpr[rt_addr];
        if (w_we && rs_addr == w_waddr && rs_addr != 5'd0)
            rs_data = w_wdata;
        if (w_we && rt_addr == w_waddr && rt_addr != 5'd0)
            rt_data = w_wdata;
    end
`else
    always_comb begin
        rs_data = (rs_addr == 5'd0) ? 32'd0 : r_gpr[rs_addr];
        rt_data = (rt_addr == 5'd0) ? 32'd0 : r_gpr[rt_addr];
    end
`endif

    assign hi        = r_hi;
    assign lo        = r_lo;
    assign halted    = (r_state == HALT);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign retired   = r_retired;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed bench for wb_regfile_stage: GPR/HI/LO commit, JAL, SYSCALL print/halt,
// retired counter and asynchronous reset.
module tb_wb_regfile_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        EN, wb_valid, RegWrite, LOWrite, HIWrite, JAL, SYSCALL, MemToReg;
    logic [4:0]  WbRegNum, rs_addr, rt_addr;
    logic [31:0] PC, R1, R2, MemData;
    logic [31:0] rs_data, rt_data, hi, lo, out_data, retired;
    logic        halted, out_valid;

    int n_vec = 0;
    int n_err = 0;

    wb_regfile_stage dut (
        .clk(clk), .rst(rst), .EN(EN), .wb_valid(wb_valid),
        .RegWrite(RegWrite), .LOWrite(LOWrite), .HIWrite(HIWrite),
        .JAL(JAL), .SYSCALL(SYSCALL), .MemToReg(MemToReg),
        .WbRegNum(WbRegNum), .PC(PC), .R1(R1), .R2(R2), .MemData(MemData),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .hi(hi), .lo(lo),
        .halted(halted), .out_valid(out_valid), .out_data(out_data),
        .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        EN = 1'b1; wb_valid = 1'b0; RegWrite = 1'b0; LOWrite = 1'b0;
        HIWrite = 1'b0; JAL = 1'b0; SYSCALL = 1'b0; MemToReg = 1'b0;
        WbRegNum = 5'd0; PC = 32'd0; R1 = 32'd0; R2 = 32'd0; MemData = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        rs_addr = a;
        #1;
        chk(tag, rs_data, exp);
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        wb_valid = 1'b1; RegWrite = 1'b1; WbRegNum = r; R1 = v;
        step();
    endtask

    initial begin
        idle();
        rs_addr = 5'd0; rt_addr = 5'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_rs", rs_data, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_hilo", hi | lo, 32'd0);
        chk("rst_outv", {31'd0, out_valid}, 32'd0);

        // ALU result write to GPR8, same-cycle read
        wb_valid = 1'b1; RegWrite = 1'b1; WbRegNum = 5'd8; R1 = 32'h1234;
        rt_addr = 5'd8;
        #1;
`ifdef WB_BYPASS_EN
        chk("same_cyc_rd", rt_data, 32'h1234);
`else
        chk("same_cyc_rd", rt_data, 32'd0);
`endif
        step();
        chk("gpr8", rt_data, 32'h1234);
        chk("ret1", retired, 32'd1);

        // load data selected by MemToReg
        wb_valid = 1'b1; RegWrite = 1'b1; MemToReg = 1'b1;
        WbRegNum = 5'd5; R1 = 32'hDEAD; MemData = 32'h77;
        step();
        rd("gpr5_mem", 5'd5, 32'h77);
        chk("ret2", retired, 32'd2);

        // JAL overrides WbRegNum and data select
        wb_valid = 1'b1; JAL = 1'b1; RegWrite = 1'b1;
        WbRegNum = 5'd3; R1 = 32'hAAAA; PC = 32'h0040_0010;
        step();
        rd("jal_gpr31", 5'd31, 32'h0040_0014);
        rd("jal_gpr3", 5'd3, 32'd0);
        chk("ret3", retired, 32'd3);

        // GPR0 write dropped but still retires
        wr(5'd0, 32'hFFFF_FFFF);
        rd("gpr0", 5'd0, 32'd0);
        chk("ret4", retired, 32'd4);

        // HI/LO together with a GPR write
        wb_valid = 1'b1; RegWrite = 1'b1; LOWrite = 1'b1; HIWrite = 1'b1;
        WbRegNum = 5'd6; R1 = 32'h11; R2 = 32'h22;
        step();
        chk("lo", lo, 32'h11);
        chk("hi", hi, 32'h22);
        rd("gpr6", 5'd6, 32'h11);
        chk("ret5", retired, 32'd5);

        // EN low and bubble both hold state
        EN = 1'b0; wb_valid = 1'b1; RegWrite = 1'b1; LOWrite = 1'b1;
        WbRegNum = 5'd7; R1 = 32'h99;
        step();
        wb_valid = 1'b0; RegWrite = 1'b1; WbRegNum = 5'd7; R1 = 32'h98;
        step();
        rd("hold_gpr7", 5'd7, 32'd0);
        chk("hold_lo", lo, 32'h11);
        chk("hold_ret", retired, 32'd5);

        // print syscall; same-cycle GPR4 write must not leak into out_data
        wr(5'd2, 32'd1);
        wr(5'd4, 32'h55);
        wb_valid = 1'b1; SYSCALL = 1'b1; RegWrite = 1'b1;
        WbRegNum = 5'd4; R1 = 32'h66;
        #1;
        chk("outv_pre", {31'd0, out_valid}, 32'd0);
        step();
        chk("outv_pulse", {31'd0, out_valid}, 32'd1);
        chk("out_data", out_data, 32'h55);
        rd("gpr4_new", 5'd4, 32'h66);
        chk("ret8", retired, 32'd8);
        step();
        chk("outv_drop", {31'd0, out_valid}, 32'd0);
        chk("out_data_hold", out_data, 32'h55);

        // halting syscall, then writes ignored
        wr(5'd5, 32'd7);
        wr(5'd2, 32'd10);
        wb_valid = 1'b1; SYSCALL = 1'b1;
        step();
        chk("halted", {31'd0, halted}, 32'd1);
        chk("halt_outv", {31'd0, out_valid}, 32'd0);
        chk("ret_halt", retired, 32'd11);
        wr(5'd9, 32'h1234_5678);
        wb_valid = 1'b1; LOWrite = 1'b1; R1 = 32'hABCD;
        step();
        rd("halt_gpr9", 5'd9, 32'd0);
        chk("halt_lo", lo, 32'h11);
        chk("ret_frozen", retired, 32'd11);
        chk("halt_stays", {31'd0, halted}, 32'd1);
        rd("gpr5_pre_rst", 5'd5, 32'd7);

        // asynchronous reset between clock edges
        #1 rst = 1'b1;
        #1;
        chk("arst_gpr5", rs_data, 32'd0);
        rt_addr = 5'd31;
        #1;
        chk("arst_gpr31", rt_data, 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd0);
        chk("arst_retired", retired, 32'd0);
        chk("arst_hi", hi, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // back in RUN after reset
        wr(5'd10, 32'hCAFE);
        rd("post_rst_wr", 5'd10, 32'hCAFE);
        chk("post_rst_ret", retired, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
